// File: rtl/move_select_rx.sv
// Receives score flits, scans the nine board cells one per cycle and reports the best free cell.
// Optional macro MOVE_SEL_TIE_LOW_EN: strict '>' replacement so ties go to the lowest index.
module move_select_rx #(
   parameter int FLIT_W = 69,
   parameter int DATA_W = 64
) (
   input  logic              Clk,
   input  logic              reset,
   input  logic [FLIT_W-1:0] flit_in,
   input  logic [8:0]        P1,
   input  logic [8:0]        P2,
   output logic              credit_en,
   output logic [1:0]        credit_out,
   output logic              move_valid,
   input  logic              move_ready,
   output logic [3:0]        move_idx,
   output logic              move_none,
   output logic              busy,
   output logic              overflow
);

   // state | meaning
   // IDLE  | no work, waiting for a flit
   // SCAN  | evaluating cells 0..8, then one cycle to publish the result
   // OUT   | result held on move_idx/move_none until move_ready
   typedef enum logic [1:0] {IDLE, SCAN, OUT} state_t;

   localparam logic signed [6:0] MIN_SCORE = 7'sb100_0000;

   state_t            state;
   logic [62:0]       work_scores;
   logic [DATA_W:0]   pend_flit;
   logic              pend_full;
   logic [8:0]        occ;
   logic [3:0]        scan_idx;
   logic [3:0]        best_idx;
   logic signed [6:0] best_score;
   logic              found;

   logic              flit_v;
   logic              handshake;
   logic              take_pend;
   logic              take_new;
   logic              load_work;
   logic [DATA_W:0]   load_flit;
   logic              load_bp;
   logic              pend_after;
   logic              new_to_pend;
   logic              drop;
   logic signed [6:0] cell_score;
   logic              cand;
   logic              better;
   logic              replace;
   logic              unused_hdr;

   assign unused_hdr  = ^flit_in[FLIT_W-2:DATA_W+1];

   assign flit_v      = flit_in[FLIT_W-1];
   assign handshake   = (state == OUT) && move_valid && move_ready;
   assign take_pend   = pend_full && ((state == IDLE) || handshake);
   assign take_new    = flit_v && (state == IDLE) && !pend_full;
   assign load_work   = take_pend || take_new;
   assign load_flit   = take_pend ? pend_flit : flit_in[DATA_W:0];
   assign load_bp     = load_flit[DATA_W-1];
   assign pend_after  = pend_full && !take_pend;
   assign new_to_pend = flit_v && !take_new && !pend_after;
   assign drop        = flit_v && !take_new && pend_after;

   always_comb begin
      cell_score = '0;
      cand       = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (scan_idx == 4'(i)) begin
            cell_score = work_scores[7*i +: 7];
            cand       = ~occ[i];
         end
      end
   end

`ifdef MOVE_SEL_TIE_LOW_EN
   assign better = cell_score > best_score;
`else
   assign better = cell_score >= best_score;
`endif
   // the found flag lets the first free cell win even when strict compare is used
   assign replace = cand && (!found || better);

   always_ff @(posedge Clk) begin
      if (reset) begin
         state       <= IDLE;
         work_scores <= '0;
         pend_flit   <= '0;
         pend_full   <= 1'b0;
         occ         <= '0;
         scan_idx    <= '0;
         best_idx    <= '0;
         best_score  <= MIN_SCORE;
         found       <= 1'b0;
         overflow    <= 1'b0;
         credit_en   <= 1'b0;
         credit_out  <= 2'b00;
         move_valid  <= 1'b0;
         move_idx    <= 4'd0;
         move_none   <= 1'b0;
         busy        <= 1'b0;
      end else begin
         credit_en <= load_work;
         pend_full <= pend_after || new_to_pend;
         if (new_to_pend) pend_flit <= flit_in[DATA_W:0];
         if (drop) overflow <= 1'b1;

         if (load_work) begin
            credit_out  <= {1'b1, load_flit[DATA_W]};
            work_scores <= load_flit[62:0];
            occ         <= P1 | P2;
            scan_idx    <= 4'd0;
            best_idx    <= 4'd0;
            best_score  <= MIN_SCORE;
            found       <= 1'b0;
            move_valid  <= 1'b0;
            // backprop flits are credited but never scanned
            if (load_bp) begin
               state <= IDLE;
               busy  <= 1'b0;
            end else begin
               state <= SCAN;
               busy  <= 1'b1;
            end
         end else begin
            case (state)
               SCAN: begin
                  if (scan_idx == 4'd9) begin
                     state      <= OUT;
                     move_valid <= 1'b1;
                     move_idx   <= found ? best_idx : 4'd15;
                     move_none  <= !found;
                  end else begin
                     if (replace) begin
                        best_idx   <= scan_idx;
                        best_score <= cell_score;
                        found      <= 1'b1;
                     end
                     scan_idx <= scan_idx + 4'd1;
                  end
               end
               OUT: begin
                  if (handshake) begin
                     state      <= IDLE;
                     busy       <= 1'b0;
                     move_valid <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
